stepdir_counter: RTL and testbench
==================================

Name: stepdir_counter

Overview:
- Step/direction receiver: the input-side counterpart of the joint step generator.
- Samples external STP/DIR lines, synchronises and glitch-filters them, and counts rising step edges into a signed 32-bit position.
- Measures the clock-cycle period between consecutive counted steps.
- Used for step-input joints (e.g. following an external controller) and for loopback checking of generated step trains.

Parameters:
- FILTER_LEN, 4: clocks a synchronised input must differ from its filtered value before the filtered value changes; legal range 1..255.
- TIMEOUT, 32'd50000000: clocks without a counted step before the period is reported as 0 (stopped).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- jointEnable  in  1  1 = count steps; 0 = ignore steps, hold position, clear period
- STP  in  1  asynchronous step input, step = rising edge
- DIR  in  1  asynchronous direction input, 1 = count up, 0 = count down
- loadEnable  in  1  one-cycle request to preset position
- loadValue  in  32 signed  preset value
- jointPosition  out  32 signed  accumulated step count
- jointPeriod  out  32  clocks between the last two counted same-direction steps; 0 = unknown/stopped
- jointDirection  out  1  direction of the last counted step
- stepStrobe  out  1  one-cycle pulse on the cycle jointPosition changes due to a step

Behaviour:
- Reset (rst_n=0 at posedge):
  - jointPosition=0, jointPeriod=0, jointDirection=0, stepStrobe=0.
  - Synchronisers, filtered STP/DIR, and filter counters cleared to 0.
  - Period counter=0; measurement-valid flag=0.
  - Reset mid-step discards any partially filtered edge.
- Synchronisation: STP and DIR each pass through a 2-flop synchroniser.
- Filter (independent per line):
  - Counter increments while sync != filtered; counter clears when they are equal.
  - When sync != filtered and counter == FILTER_LEN-1: filtered <= sync and counter <= 0.
  - Any pulse shorter than FILTER_LEN clocks after synchronisation is rejected.
- Latency: STP changes just after edge 0 → filtered STP changes at edge FILTER_LEN+2 → jointPosition/stepStrobe update at edge FILTER_LEN+3. DIR has identical latency, so DIR/STP alignment is preserved.
- Counted step: filtered-STP rising edge (registered compare of previous vs current filtered value) while jointEnable=1.
  - Filtered DIR=1: position +1; else position −1.
  - Arithmetic is 32-bit two's-complement and wraps (0x7FFFFFFF+1 → 0x80000000, 0x80000000−1 → 0x7FFFFFFF).
  - jointDirection <= filtered DIR.
  - stepStrobe=1 for exactly that cycle.
- Falling STP edges never count.
- Load: loadEnable=1 → jointPosition <= loadValue next edge. Simultaneous counted step: load wins, step is lost, stepStrobe still pulses. Period logic is unaffected by load.
- Period counter:
  - Set to 1 on each counted step; otherwise increments, saturating at TIMEOUT.
  - Period = difference in edge index between two strobes.
  - Counted step with valid=1 and same direction as the previous step: jointPeriod <= counter.
  - Counted step with valid=0, or with a direction reversal: jointPeriod <= 0 and valid <= 1.
  - Counter reaching TIMEOUT: jointPeriod <= 0, valid <= 0.
- jointEnable=0:
  - Filtering continues, so no spurious edge appears on re-enable.
  - Edges are not counted; jointPosition holds; load still works.
  - jointPeriod <= 0, valid <= 0, counter <= 0.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks while toggling STP → all outputs 0; first counted step appears no earlier than FILTER_LEN+3 clocks after release plus an STP rise.
- Forward train: FILTER_LEN=4, DIR=1, 10 STP rises every 100 clocks (50 high/50 low) → jointPosition=10; jointPeriod=0 after step 1 and 100 after steps 2–10; each strobe exactly FILTER_LEN+3=7 edges after its STP rise.
- Reversal: after forward train, DIR=0 (20 clocks before STP), 3 rises at 80-clock spacing → position 9, 8, 7; jointPeriod 0, 80, 80; jointDirection=0.
- Glitch: 3-clock STP pulse with FILTER_LEN=4 → no strobe, position unchanged; a 4-clock pulse → counted once.
- Load/collision and wrap: loadValue=0x7FFFFFFF with loadEnable coinciding with a strobe → position 0x7FFFFFFF; next up step → 0x80000000.
- Timeout/enable: TIMEOUT=1000, step then idle 1000 clocks → jointPeriod=0. jointEnable=0 during 5 rises → position unchanged; re-enable while STP high → no count until next rise.

Source files
------------

// File: rtl/stepdir_counter.sv
// Step/direction receiver: synchronises and glitch-filters STP/DIR, counts
// rising step edges into a signed position and measures the inter-step period.
module stepdir_counter #(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic [31:0] TIMEOUT    = 32'd50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jointEnable,
  input  logic               STP,
  input  logic               DIR,
  input  logic               loadEnable,
  input  logic signed [31:0] loadValue,
  output logic signed [31:0] jointPosition,
  output logic        [31:0] jointPeriod,
  output logic               jointDirection,
  output logic               stepStrobe
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  // Index 0 carries STP, index 1 carries DIR.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [7:0] flt_cnt [2];

  logic        stp_prev;
  logic        counted;
  logic        valid;
  logic [31:0] per_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 2'b00;
      sync2      <= 2'b00;
      filt       <= 2'b00;
      flt_cnt[0] <= 8'd0;
      flt_cnt[1] <= 8'd0;
    end else begin
      sync1 <= {DIR, STP};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (flt_cnt[i] == CNT_LAST) begin
            filt[i]    <= sync2[i];
            flt_cnt[i] <= 8'd0;
          end else begin
            flt_cnt[i] <= flt_cnt[i] + 8'd1;
          end
        end else begin
          flt_cnt[i] <= 8'd0;
        end
      end
    end
  end

  assign counted = filt[0] & ~stp_prev & jointEnable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stp_prev       <= 1'b0;
      stepStrobe     <= 1'b0;
      jointPosition  <= 32'sd0;
      jointDirection <= 1'b0;
    end else begin
      stp_prev   <= filt[0];
      stepStrobe <= counted;
      // A load takes precedence over a coincident step; that step is dropped.
      if (loadEnable) begin
        jointPosition <= loadValue;
      end else if (counted) begin
        jointPosition <= filt[1] ? jointPosition + 32'sd1 : jointPosition - 32'sd1;
      end
      if (counted) begin
        jointDirection <= filt[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt     <= 32'd0;
      valid       <= 1'b0;
      jointPeriod <= 32'd0;
    end else if (!jointEnable) begin
      per_cnt     <= 32'd0;
      valid       <= 1'b0;
      jointPeriod <= 32'd0;
    end else if (counted) begin
      per_cnt <= 32'd1;
      // Only a same-direction pair gives a meaningful period.
      if (valid && (filt[1] == jointDirection)) begin
        jointPeriod <= per_cnt;
      end else begin
        jointPeriod <= 32'd0;
        valid       <= 1'b1;
      end
    end else if (per_cnt >= TIMEOUT) begin
      jointPeriod <= 32'd0;
      valid       <= 1'b0;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stepdir_counter.sv
// Directed bench for stepdir_counter: reset, forward/reverse trains, glitch
// rejection, load collision with wrap, period timeout and enable gating.
module tb_stepdir_counter;

  logic               clk;
  logic               rst_n;
  logic               jointEnable;
  logic               STP;
  logic               DIR;
  logic               loadEnable;
  logic signed [31:0] loadValue;
  logic signed [31:0] jointPosition;
  logic        [31:0] jointPeriod;
  logic               jointDirection;
  logic               stepStrobe;

  int checks   = 0;
  int failures = 0;

  stepdir_counter #(
    .FILTER_LEN (4),
    .TIMEOUT    (32'd1000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jointEnable    (jointEnable),
    .STP            (STP),
    .DIR            (DIR),
    .loadEnable     (loadEnable),
    .loadValue      (loadValue),
    .jointPosition  (jointPosition),
    .jointPeriod    (jointPeriod),
    .jointDirection (jointDirection),
    .stepStrobe     (stepStrobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise STP for hi cycles then low for lo cycles; report first strobe
  // position (edges after the rise, -1 if none) and the number of strobes.
  task automatic do_step(input int hi, input int lo, output int lat, output int n);
    lat = -1;
    n   = 0;
    STP = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      @(posedge clk); #1;
      if (i == hi) STP = 1'b0;
      if (stepStrobe) begin
        n++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic idle(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (stepStrobe) n++;
    end
  endtask

  initial begin
    int lat, n, s;
    rst_n       = 1'b0;
    jointEnable = 1'b1;
    STP         = 1'b0;
    DIR         = 1'b0;
    loadEnable  = 1'b0;
    loadValue   = 32'sd0;

    // Reset held while STP toggles.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      STP = ~STP;
      @(posedge clk); #1;
    end
    STP = 1'b0;
    @(posedge clk); #1;
    check("rst_position",  jointPosition, 32'd0);
    check("rst_period",    jointPeriod,   32'd0);
    check("rst_direction", {31'd0, jointDirection}, 32'd0);
    check("rst_strobe",    {31'd0, stepStrobe},     32'd0);
    rst_n = 1'b1;
    idle(20, s);
    check("post_rst_no_strobe", s, 0);
    check("post_rst_position",  jointPosition, 32'd0);

    // Forward train: 10 rises at 100-clock spacing.
    DIR = 1'b1;
    idle(20, s);
    for (int k = 1; k <= 10; k++) begin
      do_step(50, 50, lat, n);
      check($sformatf("fwd%0d_latency", k), lat, 7);
      check($sformatf("fwd%0d_strobes", k), n, 1);
      check($sformatf("fwd%0d_position", k), jointPosition, 32'(k));
      check($sformatf("fwd%0d_period", k), jointPeriod, (k == 1) ? 32'd0 : 32'd100);
    end
    check("fwd_direction", {31'd0, jointDirection}, 32'd1);

    // Reversal at 80-clock spacing.
    DIR = 1'b0;
    idle(20, s);
    for (int k = 1; k <= 3; k++) begin
      do_step(40, 40, lat, n);
      check($sformatf("rev%0d_position", k), jointPosition, 32'(10 - k));
      check($sformatf("rev%0d_period", k), jointPeriod, (k == 1) ? 32'd0 : 32'd80);
    end
    check("rev_direction", {31'd0, jointDirection}, 32'd0);

    // Glitch rejection: 3-clock pulse dropped, 4-clock pulse counted.
    do_step(3, 40, lat, n);
    check("glitch3_strobes",  n, 0);
    check("glitch3_position", jointPosition, 32'd7);
    do_step(4, 40, lat, n);
    check("glitch4_strobes",  n, 1);
    check("glitch4_latency",  lat, 7);
    check("glitch4_position", jointPosition, 32'd6);
    check("glitch4_period",   jointPeriod, 32'd123);

    // Load coinciding with a counted step: load wins, strobe still pulses.
    DIR = 1'b1;
    idle(20, s);
    STP = 1'b1;
    idle(6, s);
    check("collide_early_strobe", s, 0);
    loadEnable = 1'b1;
    loadValue  = 32'sh7fffffff;
    @(posedge clk); #1;
    loadEnable = 1'b0;
    check("collide_strobe",    {31'd0, stepStrobe}, 32'd1);
    check("collide_position",  jointPosition, 32'h7fffffff);
    check("collide_direction", {31'd0, jointDirection}, 32'd1);
    idle(43, s);
    STP = 1'b0;
    idle(50, s);
    do_step(50, 50, lat, n);
    check("wrap_up_position", jointPosition, 32'h80000000);
    check("wrap_up_period",   jointPeriod,   32'd100);
    DIR = 1'b0;
    do_step(50, 50, lat, n);
    check("wrap_dn_position", jointPosition, 32'h7fffffff);
    check("wrap_dn_period",   jointPeriod,   32'd0);

    // Timeout clears the period after 1000 idle clocks.
    do_step(50, 50, lat, n);
    check("to_position", jointPosition, 32'h7ffffffe);
    check("to_period",   jointPeriod,   32'd100);
    idle(800, s);
    check("to_before_period", jointPeriod, 32'd100);
    idle(300, s);
    check("to_after_period",  jointPeriod, 32'd0);
    do_step(50, 50, lat, n);
    check("to_next_position", jointPosition, 32'h7ffffffd);
    check("to_next_period",   jointPeriod,   32'd0);

    // Disabled: rises ignored, position held, period cleared.
    jointEnable = 1'b0;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      do_step(20, 20, lat, n);
      s += n;
    end
    check("dis_strobes",  s, 0);
    check("dis_position", jointPosition, 32'h7ffffffd);
    check("dis_period",   jointPeriod,   32'd0);
    STP = 1'b1;
    idle(20, s);
    jointEnable = 1'b1;
    idle(30, n);
    STP = 1'b0;
    idle(20, s);
    check("reen_high_strobes", n + s, 0);
    check("reen_high_position", jointPosition, 32'h7ffffffd);
    do_step(20, 20, lat, n);
    check("reen_strobes",  n, 1);
    check("reen_position", jointPosition, 32'h7ffffffc);
    check("reen_period",   jointPeriod,   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
